mips_mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit with architectural HI/LO registers. It sits beside the

---
 rtl/mips_mult_div_unit.sv | 168 ++++++++++++++++
 tb/tb_mips_mult_div_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per clock, sign fix-up on the final cycle.
module mips_mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             is_div_q, is_div_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             bzero_q, bzero_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_trial;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic               neg_result;

  assign abs_a = a[WIDTH-1] ? -a : a;
  assign abs_b = b[WIDTH-1] ? -b : b;

  // acc holds the product high half (multiply) or partial remainder (divide);
  // low holds the multiplier bits being consumed or the quotient being built.
  assign mul_sum   = low_q[0] ? (acc_q + {1'b0, opb_q}) : acc_q;
  assign div_shift = {acc_q[WIDTH-1:0], low_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opb_q};

  assign neg_result = sign_a_q ^ sign_b_q;
  assign prod_raw   = {acc_q[WIDTH-1:0], low_q};
  assign prod_fix   = neg_result ? -prod_raw : prod_raw;
  assign quot_fix   = neg_result ? -low_q : low_q;
  assign rem_fix    = sign_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    low_d    = low_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    bzero_d  = bzero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!op[2]) begin
            state_d  = RUN;
            count_d  = '0;
            acc_d    = '0;
            low_d    = op[0] ? a : abs_a;
            opb_d    = op[0] ? b : abs_b;
            is_div_d = op[1];
            sign_a_d = ~op[0] & a[WIDTH-1];
            sign_b_d = ~op[0] & b[WIDTH-1];
            bzero_d  = op[1] & (b == '0);
          end else if (!op[1]) begin
            if (op[0]) lo_d = a;
            else       hi_d = a;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            if (!div_trial[WIDTH]) begin
              acc_d = div_trial;
              low_d = {low_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = div_shift;
              low_d = {low_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = {1'b0, mul_sum[WIDTH:1]};
            low_d = {mul_sum[0], low_q[WIDTH-1:1]};
          end
          count_d = count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
        // A flush arriving on the commit edge still suppresses the write.
        if (!abort) begin
          done_d = 1'b1;
          dbz_d  = bzero_q;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else if (!bzero_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      low_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      bzero_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      low_q    <= low_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      bzero_q  <= bzero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mips_mult_div_unit.sv
// Directed bench for mips_mult_div_unit: arithmetic, latency, abort, reset and back-to-back issue.
module tb_mips_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        abort;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int compared;
  int mismatched;

  mips_mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .abort(abort),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .hi(hi),
    .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entered at a negedge; issues one long op and returns at the negedge where busy has dropped.
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        output int cycles, output logic saw_done, output logic saw_dbz);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    saw_done = done;
    saw_dbz  = div_by_zero;
  endtask

  task automatic write_hilo(input logic [31:0] hv, input logic [31:0] lv);
    start = 1'b1; op = 3'b100; a = hv;
    @(negedge clk);
    op = 3'b101; a = lv;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0; abort = 1'b0;
    #12;
    compared++;
    if ({busy, done, div_by_zero, hi, lo} !== 67'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: got busy=%b done=%b dbz=%b hi=%h lo=%h, want all 0",
               busy, done, div_by_zero, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multu;
    int cyc; logic d, z;
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, d, z);
    compared++;
    if (cyc !== 33) begin
      mismatched++; $display("[TB] FAIL multu_latency: got %0d, want 33", cyc);
    end
    compared++;
    if ({d, hi, lo} !== {1'b1, 32'hFFFFFFFE, 32'h00000001}) begin
      mismatched++;
      $display("[TB] FAIL multu_result: got done=%b hi=%h lo=%h, want 1 fffffffe 00000001", d, hi, lo);
    end
    @(negedge clk);
    compared++;
    if (done !== 1'b0) begin
      mismatched++; $display("[TB] FAIL done_pulse_width: got done=%b one cycle later, want 0", done);
    end
  endtask

  task automatic test_mult_signed;
    int cyc; logic d, z;
    run_op(3'b000, 32'hFFFFFFFD, 32'd7, cyc, d, z);
    compared++;
    if (cyc !== 33) begin
      mismatched++; $display("[TB] FAIL mult_busy_cycles: got %0d, want 33", cyc);
    end
    compared++;
    if ({d, hi, lo} !== {1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB}) begin
      mismatched++;
      $display("[TB] FAIL mult_result: got done=%b hi=%h lo=%h, want 1 ffffffff ffffffeb", d, hi, lo);
    end
  endtask

  task automatic test_divide;
    int cyc; logic d, z;
    run_op(3'b010, 32'hFFFFFFF9, 32'd2, cyc, d, z);
    compared++;
    if ({d, z, hi, lo} !== {2'b10, 32'hFFFFFFFF, 32'hFFFFFFFD}) begin
      mismatched++;
      $display("[TB] FAIL div_signed: got done=%b dbz=%b hi=%h lo=%h, want 1 0 ffffffff fffffffd", d, z, hi, lo);
    end
    run_op(3'b011, 32'd100, 32'd7, cyc, d, z);
    compared++;
    if ({d, hi, lo} !== {1'b1, 32'd2, 32'd14}) begin
      mismatched++;
      $display("[TB] FAIL divu_result: got done=%b hi=%0d lo=%0d, want 1 2 14", d, hi, lo);
    end
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, cyc, d, z);
    compared++;
    if ({d, z, hi, lo} !== {2'b10, 32'h00000000, 32'h80000000}) begin
      mismatched++;
      $display("[TB] FAIL div_overflow: got done=%b dbz=%b hi=%h lo=%h, want 1 0 00000000 80000000", d, z, hi, lo);
    end
    run_op(3'b010, 32'd7, 32'hFFFFFFFE, cyc, d, z);
    compared++;
    if ({hi, lo} !== {32'd1, 32'hFFFFFFFD}) begin
      mismatched++;
      $display("[TB] FAIL div_neg_divisor: got hi=%h lo=%h, want 00000001 fffffffd", hi, lo);
    end
  endtask

  task automatic test_div_by_zero;
    int cyc; logic d, z;
    abort = 1'b1;
    write_hilo(32'h1234, 32'h5678);
    abort = 1'b0;
    compared++;
    if ({busy, done, hi, lo} !== {2'b00, 32'h1234, 32'h5678}) begin
      mismatched++;
      $display("[TB] FAIL mthi_mtlo: got busy=%b done=%b hi=%h lo=%h, want 0 0 00001234 00005678", busy, done, hi, lo);
    end
    run_op(3'b011, 32'd5, 32'd0, cyc, d, z);
    compared++;
    if ({cyc, d, z} !== {32'd33, 2'b11}) begin
      mismatched++; $display("[TB] FAIL divzero_flags: got cycles=%0d done=%b dbz=%b, want 33 1 1", cyc, d, z);
    end
    compared++;
    if ({hi, lo} !== {32'h1234, 32'h5678}) begin
      mismatched++; $display("[TB] FAIL divzero_hilo: got hi=%h lo=%h, want 00001234 00005678", hi, lo);
    end
  endtask

  task automatic test_abort;
    logic seen_done;
    start = 1'b1; op = 3'b000; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    compared++;
    if ({busy, done} !== 2'b00) begin
      mismatched++; $display("[TB] FAIL abort_busy: got busy=%b done=%b, want 0 0", busy, done);
    end
    compared++;
    if ({hi, lo} !== {32'h1234, 32'h5678}) begin
      mismatched++; $display("[TB] FAIL abort_hilo: got hi=%h lo=%h, want 00001234 00005678", hi, lo);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    compared++;
    if (seen_done !== 1'b0) begin
      mismatched++; $display("[TB] FAIL abort_no_done: got activity=%b after abort, want 0", seen_done);
    end
  endtask

  task automatic test_abort_finish;
    start = 1'b1; op = 3'b001; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 32; i++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    compared++;
    if ({busy, done, hi, lo} !== {2'b00, 32'h1234, 32'h5678}) begin
      mismatched++;
      $display("[TB] FAIL abort_on_finish: got busy=%b done=%b hi=%h lo=%h, want 0 0 00001234 00005678", busy, done, hi, lo);
    end
  endtask

  task automatic test_back_to_back;
    int cyc; logic d, z;
    start = 1'b1; op = 3'b010; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got busy=%b done=%b hi=%h lo=%h, want all 0", busy, done, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3'b001, 32'd6, 32'd7, cyc, d, z);
    compared++;
    if ({d, hi, lo} !== {1'b1, 32'd0, 32'd42}) begin
      mismatched++; $display("[TB] FAIL b2b_first: got done=%b hi=%h lo=%h, want 1 0 42", d, hi, lo);
    end
    run_op(3'b000, 32'd5, 32'hFFFFFFFA, cyc, d, z);
    compared++;
    if ({cyc, d, hi, lo} !== {32'd33, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFE2}) begin
      mismatched++;
      $display("[TB] FAIL b2b_second: got cycles=%0d done=%b hi=%h lo=%h, want 33 1 ffffffff ffffffe2", cyc, d, hi, lo);
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_multu();
    test_mult_signed();
    test_divide();
    test_div_by_zero();
    test_abort();
    test_abort_finish();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no completion, want finish before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule
